// File: rtl/pipeline_mem_stage_pkg.sv
// rtl/pipeline_mem_stage_pkg.sv - shared codes and state type for the MEM stage
package pipeline_mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/pipeline_mem_stage_mem_align.sv
// rtl/pipeline_mem_stage_mem_align.sv - load extraction, store lane placement, misalign check
module mem_align
    import pipeline_mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic            misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{off, 3'b000} +: 8];
    assign rd_half = rdata[{off[1], 4'b0000} +: 16];

    // Decode width from funct3; store-only undefined codes (100/101) fall back to word
    always_comb begin
        load_data = rdata;
        wdata     = store_data;
        wstrb     = is_store ? 4'b1111 : 4'b0000;
        misalign  = (off != 2'b00);
        case (funct3)
            F3_LB: begin
                misalign  = 1'b0;
                load_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
                wdata     = {4{store_data[7:0]}};
                wstrb     = is_store ? (4'b0001 << off) : 4'b0000;
            end
            F3_LH: begin
                misalign  = off[0];
                load_data = {{(XLEN-16){rd_half[15]}}, rd_half};
                wdata     = {2{store_data[15:0]}};
                wstrb     = is_store ? (4'b0011 << off) : 4'b0000;
            end
            F3_LBU: begin
                if (!is_store) begin
                    misalign  = 1'b0;
                    load_data = {{(XLEN-8){1'b0}}, rd_byte};
                end
            end
            F3_LHU: begin
                if (!is_store) begin
                    misalign  = off[0];
                    load_data = {{(XLEN-16){1'b0}}, rd_half};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// rtl/pipeline_mem_stage.sv - MEM stage with req/ack data memory access and MEM/WB register
module pipeline_mem_stage
    import pipeline_mem_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in_MEM,
    input  logic [XLEN-1:0]       PC4_in_MEM,
    input  logic [XLEN-1:0]       ALU_in_MEM,
    input  logic [XLEN-1:0]       Data_in_MEM,
    input  logic                  MemRead_in_MEM,
    input  logic                  MemWrite_in_MEM,
    input  logic [2:0]            Funct3_in_MEM,
    input  logic [1:0]            MemtoReg_in_MEM,
    input  logic                  RegWrite_in_MEM,
    input  logic [REG_ADDR_W-1:0] Rd_in_MEM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic [XLEN-1:0]       dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_MEM,
    output logic                  valid_out_WB,
    output logic [XLEN-1:0]       PC4_out_WB,
    output logic [XLEN-1:0]       ALU_out_WB,
    output logic [XLEN-1:0]       DMem_data_WB,
    output logic [1:0]            MemtoReg_out_WB,
    output logic                  RegWrite_out_WB,
    output logic [REG_ADDR_W-1:0] Rd_out_WB,
    output logic                  misalign_out_WB
);

    mem_state_e state_q, state_d;

    logic            mem_op, is_load, is_store, misalign, start_access, bad_op;
    logic [XLEN-1:0] load_data, st_wdata;
    logic [3:0]      st_wstrb;

    assign is_load      = MemRead_in_MEM;
    assign is_store     = MemWrite_in_MEM & ~MemRead_in_MEM;
    assign mem_op       = valid_in_MEM & (MemRead_in_MEM | MemWrite_in_MEM);
    assign start_access = mem_op & ~misalign;
    assign bad_op       = mem_op & misalign;

    // The EX/MEM bundle is held by stall_MEM for the whole access, so alignment can
    // work off the live inputs both at issue and when the ack returns.
    mem_align #(.XLEN(XLEN)) u_align (
        .funct3     (Funct3_in_MEM),
        .off        (ALU_in_MEM[1:0]),
        .is_store   (is_store),
        .store_data (Data_in_MEM),
        .rdata      (dmem_rdata),
        .load_data  (load_data),
        .wdata      (st_wdata),
        .wstrb      (st_wstrb),
        .misalign   (misalign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and stall: stall from issue until the ack cycle
    always_comb begin
        state_d   = state_q;
        stall_MEM = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_access) begin
                    stall_MEM = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) state_d   = ST_IDLE;
                else          stall_MEM = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory request registers: latched at issue, held until ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= 4'b0000;
        end else if (state_q == ST_IDLE && start_access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ALU_in_MEM[XLEN-1:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_wstrb <= st_wstrb;
        end else if (state_q == ST_ACCESS && dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
        end
    end

    // MEM/WB register: bundle on completion, bubble while an access is pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out_WB    <= 1'b0;
            PC4_out_WB      <= '0;
            ALU_out_WB      <= '0;
            DMem_data_WB    <= '0;
            MemtoReg_out_WB <= 2'b00;
            RegWrite_out_WB <= 1'b0;
            Rd_out_WB       <= '0;
            misalign_out_WB <= 1'b0;
        end else begin
            PC4_out_WB      <= PC4_in_MEM;
            ALU_out_WB      <= ALU_in_MEM;
            MemtoReg_out_WB <= MemtoReg_in_MEM;
            Rd_out_WB       <= Rd_in_MEM;
            valid_out_WB    <= 1'b0;
            RegWrite_out_WB <= 1'b0;
            misalign_out_WB <= 1'b0;
            DMem_data_WB    <= '0;
            if (state_q == ST_IDLE) begin
                if (valid_in_MEM && !start_access) begin
                    valid_out_WB    <= 1'b1;
                    RegWrite_out_WB <= RegWrite_in_MEM & ~bad_op;
                    misalign_out_WB <= bad_op;
                end
            end else if (dmem_ack) begin
                valid_out_WB    <= valid_in_MEM;
                RegWrite_out_WB <= RegWrite_in_MEM;
                DMem_data_WB    <= is_load ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb/tb_pipeline_mem_stage.sv - directed vector bench for pipeline_mem_stage
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in_MEM;
    logic [31:0] PC4_in_MEM, ALU_in_MEM, Data_in_MEM;
    logic        MemRead_in_MEM, MemWrite_in_MEM;
    logic [2:0]  Funct3_in_MEM;
    logic [1:0]  MemtoReg_in_MEM;
    logic        RegWrite_in_MEM;
    logic [4:0]  Rd_in_MEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic        stall_MEM;
    logic        valid_out_WB;
    logic [31:0] PC4_out_WB, ALU_out_WB, DMem_data_WB;
    logic [1:0]  MemtoReg_out_WB;
    logic        RegWrite_out_WB;
    logic [4:0]  Rd_out_WB;
    logic        misalign_out_WB;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in_MEM    (valid_in_MEM),
        .PC4_in_MEM      (PC4_in_MEM),
        .ALU_in_MEM      (ALU_in_MEM),
        .Data_in_MEM     (Data_in_MEM),
        .MemRead_in_MEM  (MemRead_in_MEM),
        .MemWrite_in_MEM (MemWrite_in_MEM),
        .Funct3_in_MEM   (Funct3_in_MEM),
        .MemtoReg_in_MEM (MemtoReg_in_MEM),
        .RegWrite_in_MEM (RegWrite_in_MEM),
        .Rd_in_MEM       (Rd_in_MEM),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .stall_MEM       (stall_MEM),
        .valid_out_WB    (valid_out_WB),
        .PC4_out_WB      (PC4_out_WB),
        .ALU_out_WB      (ALU_out_WB),
        .DMem_data_WB    (DMem_data_WB),
        .MemtoReg_out_WB (MemtoReg_out_WB),
        .RegWrite_out_WB (RegWrite_out_WB),
        .Rd_out_WB       (Rd_out_WB),
        .misalign_out_WB (misalign_out_WB)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic        mr, mw;
        logic [2:0]  f3;
        logic [1:0]  mtr;
        logic        rw;
        logic        e_valid, e_rw, e_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in_MEM    = 1'b0;
        MemRead_in_MEM  = 1'b0;
        MemWrite_in_MEM = 1'b0;
        RegWrite_in_MEM = 1'b0;
        Funct3_in_MEM   = 3'b000;
        MemtoReg_in_MEM = 2'b00;
        ALU_in_MEM      = '0;
        Data_in_MEM     = '0;
        PC4_in_MEM      = '0;
        Rd_in_MEM       = '0;
    endtask

    // Issue one aligned memory op, ack after wait_cycles ACCESS cycles, return stall count
    task automatic run_mem(input string name, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic mr, input logic mw, input logic [2:0] f3, input logic rw,
                           input int wait_cycles, input logic [31:0] rdata,
                           input logic e_we, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                           output int stalls);
        @(negedge clk);
        valid_in_MEM    = 1'b1;
        ALU_in_MEM      = addr;
        Data_in_MEM     = sdata;
        PC4_in_MEM      = 32'h0000_0804;
        MemRead_in_MEM  = mr;
        MemWrite_in_MEM = mw;
        Funct3_in_MEM   = f3;
        MemtoReg_in_MEM = mr ? 2'b01 : 2'b00;
        RegWrite_in_MEM = rw;
        Rd_in_MEM       = 5'd9;
        dmem_ack        = 1'b0;
        stalls          = 0;
        #1;
        chk({name, " idle req"}, {31'd0, dmem_req}, 32'd0);
        if (stall_MEM) stalls++;
        for (int i = 0; i <= wait_cycles; i++) begin
            @(negedge clk);
            chk({name, " req"}, {31'd0, dmem_req}, 32'd1);
            chk({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
            chk({name, " bubble"}, {31'd0, valid_out_WB}, 32'd0);
            if (i == 0) begin
                chk({name, " we"}, {31'd0, dmem_we}, {31'd0, e_we});
                chk({name, " wstrb"}, {28'd0, dmem_wstrb}, {28'd0, e_strb});
                if (e_we) chk({name, " wdata"}, dmem_wdata, e_wdata);
            end
            if (i < wait_cycles) begin
                #1;
                if (stall_MEM) stalls++;
            end else begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                #1;
                chk({name, " stall on ack"}, {31'd0, stall_MEM}, 32'd0);
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        chk({name, " req dropped"}, {31'd0, dmem_req}, 32'd0);
        chk({name, " wb valid"}, {31'd0, valid_out_WB}, 32'd1);
        chk({name, " wb rd"}, {27'd0, Rd_out_WB}, 32'd9);
    endtask

    int stalls;

    initial begin
        vecs[0] = '{"add",       1'b1, 32'h0000_1234, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{"lw_mis",    1'b1, 32'h0000_0302, 1'b1, 1'b0, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"sh_mis",    1'b1, 32'h0000_0203, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"lh_mis",    1'b1, 32'h0000_0101, 1'b1, 1'b0, 3'b001, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"invalid",   1'b0, 32'h0000_0100, 1'b1, 1'b0, 3'b010, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"jal",       1'b1, 32'h0000_0055, 1'b0, 1'b0, 3'b000, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"undef_ld",  1'b1, 32'h0000_0301, 1'b1, 1'b0, 3'b011, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{"undef_st",  1'b1, 32'h0000_0305, 1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, valid_out_WB}, 32'd0);
        chk("reset req", {31'd0, dmem_req}, 32'd0);
        chk("reset stall", {31'd0, stall_MEM}, 32'd0);
        chk("reset misalign", {31'd0, misalign_out_WB}, 32'd0);
        chk("reset alu", ALU_out_WB, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in_MEM    = vecs[i].valid;
            ALU_in_MEM      = vecs[i].alu;
            PC4_in_MEM      = vecs[i].alu + 32'd4;
            Data_in_MEM     = 32'hCAFE_F00D;
            MemRead_in_MEM  = vecs[i].mr;
            MemWrite_in_MEM = vecs[i].mw;
            Funct3_in_MEM   = vecs[i].f3;
            MemtoReg_in_MEM = vecs[i].mtr;
            RegWrite_in_MEM = vecs[i].rw;
            Rd_in_MEM       = 5'd7;
            #1;
            chk({vecs[i].name, " stall"}, {31'd0, stall_MEM}, 32'd0);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " valid"}, {31'd0, valid_out_WB}, {31'd0, vecs[i].e_valid});
            chk({vecs[i].name, " regwrite"}, {31'd0, RegWrite_out_WB}, {31'd0, vecs[i].e_rw});
            chk({vecs[i].name, " misalign"}, {31'd0, misalign_out_WB}, {31'd0, vecs[i].e_mis});
            chk({vecs[i].name, " req"}, {31'd0, dmem_req}, 32'd0);
            chk({vecs[i].name, " stall after"}, {31'd0, stall_MEM}, 32'd0);
            if (vecs[i].e_valid) begin
                chk({vecs[i].name, " alu"}, ALU_out_WB, vecs[i].alu);
                chk({vecs[i].name, " pc4"}, PC4_out_WB, vecs[i].alu + 32'd4);
                chk({vecs[i].name, " mtr"}, {30'd0, MemtoReg_out_WB}, {30'd0, vecs[i].mtr});
                chk({vecs[i].name, " rd"}, {27'd0, Rd_out_WB}, 32'd7);
                chk({vecs[i].name, " dmem data"}, DMem_data_WB, 32'd0);
            end
        end

        run_mem("lb", 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 3, 32'h80FF_0000,
                1'b0, 4'b0000, 32'h0, stalls);
        chk("lb stalls", stalls, 32'd4);
        chk("lb data", DMem_data_WB, 32'hFFFF_FF80);
        chk("lb regwrite", {31'd0, RegWrite_out_WB}, 32'd1);
        idle_inputs();

        run_mem("lhu", 32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 0, 32'hBEEF_1234,
                1'b0, 4'b0000, 32'h0, stalls);
        chk("lhu stalls", stalls, 32'd1);
        chk("lhu data", DMem_data_WB, 32'h0000_BEEF);
        idle_inputs();

        run_mem("lh", 32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 0, 32'h8001_5555,
                1'b0, 4'b0000, 32'h0, stalls);
        chk("lh data", DMem_data_WB, 32'hFFFF_8001);
        idle_inputs();

        run_mem("sb", 32'h0000_0201, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 1'b0, 1, 32'h1111_1111,
                1'b1, 4'b0010, 32'hABAB_ABAB, stalls);
        chk("sb stalls", stalls, 32'd2);
        chk("sb regwrite", {31'd0, RegWrite_out_WB}, 32'd0);
        chk("sb data", DMem_data_WB, 32'd0);
        idle_inputs();

        run_mem("sh", 32'h0000_0202, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, 1'b0, 0, 32'h0,
                1'b1, 4'b1100, 32'hBEEF_BEEF, stalls);
        idle_inputs();

        run_mem("sw", 32'h0000_0300, 32'h1234_5678, 1'b0, 1'b1, 3'b010, 1'b0, 0, 32'h0,
                1'b1, 4'b1111, 32'h1234_5678, stalls);
        idle_inputs();

        // Reset while an access is outstanding, then a stray ack
        @(negedge clk);
        valid_in_MEM    = 1'b1;
        ALU_in_MEM      = 32'h0000_0400;
        MemRead_in_MEM  = 1'b1;
        Funct3_in_MEM   = 3'b010;
        RegWrite_in_MEM = 1'b1;
        @(negedge clk);
        chk("rst pre req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst req", {31'd0, dmem_req}, 32'd0);
        chk("rst valid", {31'd0, valid_out_WB}, 32'd0);
        chk("rst regwrite", {31'd0, RegWrite_out_WB}, 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        idle_inputs();
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("late ack stall", {31'd0, stall_MEM}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late ack valid", {31'd0, valid_out_WB}, 32'd0);
        chk("late ack data", DMem_data_WB, 32'd0);
        chk("late ack req", {31'd0, dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
- MEM stage plus MEM/WB pipeline register. Accepts EX/MEM bundle, runs data-memory access over a req/ack handshake, aligns load data and store strobes, and registers the WB bundle.
- The WB bundle (PC4, ALU result, load data, MemtoReg) feeds the write-back mux.
- Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_in_MEM  in  1  EX/MEM bundle valid
- PC4_in_MEM  in  XLEN  PC+4 of instruction
- ALU_in_MEM  in  XLEN  ALU result / effective address
- Data_in_MEM  in  XLEN  store data (rs2)
- MemRead_in_MEM  in  1  load
- MemWrite_in_MEM  in  1  store
- Funct3_in_MEM  in  3  width/sign code
- MemtoReg_in_MEM  in  2  00 ALU, 01 load, 10 PC4
- RegWrite_in_MEM  in  1  write-enable
- Rd_in_MEM  in  REG_ADDR_W  destination
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write request
- dmem_addr  out  XLEN  word-aligned address
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_rdata  in  XLEN  read data, valid with ack
- dmem_ack  in  1  access complete
- stall_MEM  out  1  hold EX/MEM and earlier stages
- valid_out_WB, PC4_out_WB, ALU_out_WB, DMem_data_WB, MemtoReg_out_WB, RegWrite_out_WB, Rd_out_WB  out  1/XLEN/XLEN/XLEN/2/1/REG_ADDR_W  MEM/WB register
- misalign_out_WB  out  1  misaligned access flag for the WB instruction

Behaviour:
- Reset (rst_n=0 at edge):
  - State goes to IDLE.
  - All WB outputs, dmem_* outputs and misalign_out_WB go to 0.
  - Any outstanding request is dropped; a late ack is then ignored in IDLE.
- States:
  - IDLE: no request outstanding.
  - ACCESS: request held, waiting for ack.
- Memory op: valid_in_MEM & (MemRead|MemWrite). Loads take priority if both are set.
- Misalignment:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠00 is misaligned.
- IDLE, non-memory op or misaligned op:
  - stall_MEM=0. WB register loads the bundle next edge (latency 1).
  - Misaligned op: RegWrite_out_WB=0, misalign_out_WB=1, no dmem request.
- IDLE, aligned memory op:
  - stall_MEM=1 combinationally.
  - At the edge: dmem_req=1, dmem_we, dmem_addr={addr[31:2],00}, dmem_wdata and dmem_wstrb latch; state goes to ACCESS.
  - WB register loads a bubble (valid=0, RegWrite=0).
- ACCESS, ack=0: stall_MEM=1, all dmem_* outputs held stable.
- ACCESS, ack=1:
  - stall_MEM=0, so upstream advances on the same edge.
  - WB register loads the bundle, with DMem_data_WB = aligned dmem_rdata (loads) or 0 (stores).
  - dmem_req drops; state returns to IDLE.
  - Minimum memory-op latency is 2 cycles; back-to-back memory ops are therefore separated by one bubble.
- Load alignment, with off=addr[1:0]:
  - LB/LBU: byte off, sign/zero extended.
  - LH/LHU: half off[1], sign/zero extended.
  - LW: full word.
- Store alignment:
  - SB: wstrb=0001<<off, wdata=byte replicated ×4.
  - SH: wstrb=0011<<off, wdata=half replicated ×2.
  - SW: wstrb=1111.
  - Loads: wstrb=0000.
- Undefined funct3: treated as a word access.
- Invalid input (valid_in_MEM=0) in IDLE: bubble loaded, no request.
- dmem_ack while in IDLE: ignored.

Decomposition:
- Shared package holds:
  - funct3 load/store codes (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW=000/001/010)
  - MemtoReg encodings (ALU=00, MEM=01, PC4=10)
  - FSM state enum (IDLE, ACCESS)
- One combinational sub-module, mem_align: produces load extraction/extension, store strobes and replication, and the misalign flag.

Test Plan:
- ADD result 0x0000_1234, MemtoReg=00 → next cycle ALU_out_WB=0x1234, valid_out_WB=1, stall never asserted, dmem_req=0.
- LB addr 0x103, ack after 3 ACCESS cycles, rdata 0x80FF_0000 → stall high for 4 cycles, dmem_addr=0x100 held stable, DMem_data_WB=0xFFFF_FF80.
- LHU addr 0x102, rdata 0xBEEF_1234, ack in first ACCESS cycle → DMem_data_WB=0x0000_BEEF, total latency 2.
- SB addr 0x201, data 0x0000_00AB → dmem_we=1, wstrb=0010, wdata=0xABAB_ABAB, RegWrite_out_WB=0.
- LW addr 0x302 → no dmem_req, misalign_out_WB=1, RegWrite_out_WB=0, no stall.
- rst_n low during ACCESS → next edge dmem_req=0, state IDLE, all WB outputs 0; a subsequent ack is ignored.
